fsm_down_timer: RTL and testbench

Loadable down-counting timer FSM, the counting-down counterpart to the team's free-running up-counter FSM. It loads a start value on a `start` strobe and decrements once per enabled cycle. It pauses while the enable is low and flags terminal count with a one-cycle `done` pulse. Optional auto-reload turns it into a periodic tick generator for downstream control logic.

---
 rtl/fsm_down_timer.sv | 98 +++++++++
 tb/tb_fsm_down_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_down_timer.sv
// Loadable down-counting timer FSM: loads on start, decrements while enabled,
// pulses done for one cycle at terminal count, optionally reloads for periodic ticks.
module fsm_down_timer #(
  parameter int unsigned WIDTH       = 8,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             load_zero;
  logic             at_last;

  assign load_zero = (load_val == '0);
  // Treat 0 like 1 so a corrupted count can never wrap below zero.
  assign at_last   = (count_q <= WIDTH'(1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (abort) begin
          count_d = '0;
        end else if (start) begin
          state_d = load_zero ? StDone : StRun;
          count_d = load_val;
        end
      end
      StRun, StPause: begin
        if (abort) begin
          state_d = StIdle;
          count_d = '0;
        end else if (!en) begin
          state_d = StPause;
        end else if (at_last) begin
          state_d = StDone;
          count_d = '0;
        end else begin
          state_d = StRun;
          count_d = count_q - WIDTH'(1);
        end
      end
      StDone: begin
        if (abort) begin
          state_d = StIdle;
          count_d = '0;
        end else if (start) begin
          state_d = load_zero ? StDone : StRun;
          count_d = load_val;
        end else if (AUTO_RELOAD && !load_zero) begin
          state_d = StRun;
          count_d = load_val;
        end else begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == StRun) || (state_q == StPause);
  assign done  = (state_q == StDone);
  assign state = state_q;

endmodule

// File: tb/tb_fsm_down_timer.sv
// Bench for fsm_down_timer: directed scenarios plus random traffic, two instances
// (plain and auto-reload) checked every cycle against a behavioural model.
module tb_fsm_down_timer;

  logic       clk = 1'b0;
  logic       reset_n, start, en, abort;
  logic [7:0] load_val;
  logic [7:0] count0, count1;
  logic       busy0, busy1, done0, done1;
  logic [1:0] state0, state1;

  int compared   = 0;
  int mismatched = 0;

  // Model: phase 0 idle, 1 counting, 2 paused, 3 terminal; plus remaining count.
  int m_ph [2];
  int m_cnt[2];

  always #5 clk = ~clk;

  fsm_down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .load_val(load_val), .en(en),
    .abort(abort), .count(count0), .busy(busy0), .done(done0), .state(state0)
  );

  fsm_down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .load_val(load_val), .en(en),
    .abort(abort), .count(count1), .busy(busy1), .done(done1), .state(state1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k]  = 0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    int lv;
    bit reload;
    lv = int'(load_val);
    for (int k = 0; k < 2; k++) begin
      if (abort) begin
        m_ph[k]  = 0;
        m_cnt[k] = 0;
      end else if (m_ph[k] == 1 || m_ph[k] == 2) begin
        if (!en) m_ph[k] = 2;
        else if (m_cnt[k] == 1) begin
          m_ph[k]  = 3;
          m_cnt[k] = 0;
        end else begin
          m_ph[k]  = 1;
          m_cnt[k] = m_cnt[k] - 1;
        end
      end else begin
        reload = start || (m_ph[k] == 3 && k == 1 && lv != 0);
        if (reload) begin
          m_cnt[k] = lv;
          m_ph[k]  = (lv == 0) ? 3 : 1;
        end else if (m_ph[k] == 3) begin
          m_ph[k]  = 0;
          m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_count", k), (k == 0) ? count0 : count1, m_cnt[k]);
      chk($sformatf("d%0d_busy", k), (k == 0) ? busy0 : busy1, (m_ph[k] == 1 || m_ph[k] == 2));
      chk($sformatf("d%0d_done", k), (k == 0) ? done0 : done1, (m_ph[k] == 3));
      chk($sformatf("d%0d_state", k), (k == 0) ? state0 : state1, m_ph[k]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    en       = 1'b0;
    abort    = 1'b0;
    load_val = '0;
    model_reset();
    #3;
    check_model();
    chk("rst_count", count0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-run takes effect before the next edge
    load_val = 8'd5; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midrun_count", count0, 3);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_count", count0, 0);
    chk("async_rst_busy", busy0, 0);
    chk("async_rst_state", state0, 0);
    check_model();
    @(negedge clk);
    reset_n = 1'b1;

    // Basic countdown
    load_val = 8'd4; start = 1'b1;
    tick();
    chk("basic_first", count0, 4);
    chk("basic_busy_first", busy0, 1);
    start = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      tick();
      chk("basic_count", count0, i);
      chk("basic_done", done0, (i == 0));
      chk("basic_busy", busy0, (i != 0));
    end
    tick();
    chk("basic_idle", state0, 0);

    // Pause for three cycles at count 3
    load_val = 8'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pause_pre", count0, 3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_state", state0, 2);
      chk("pause_hold", count0, 3);
    end
    en = 1'b1;
    tick();
    chk("resume_2", count0, 2);
    tick();
    chk("resume_1", count0, 1);
    chk("resume_nodone", done0, 0);
    tick();
    chk("pause_done", done0, 1);
    tick();

    // Restart ignored mid-run, abort at count 1 suppresses done
    load_val = 8'd10; start = 1'b1;
    tick();
    chk("abort_load", count0, 10);
    start = 1'b0;
    repeat (3) tick();
    chk("abort_at7", count0, 7);
    start = 1'b1; load_val = 8'd2;
    tick();
    chk("restart_ignored", count0, 6);
    chk("restart_state", state0, 1);
    start = 1'b0;
    repeat (5) tick();
    chk("abort_pre", count0, 1);
    abort = 1'b1;
    tick();
    chk("abort_state", state0, 0);
    chk("abort_count", count0, 0);
    chk("abort_nodone", done0, 0);
    abort = 1'b0;
    tick();
    chk("abort_nodone2", done0, 0);

    // Zero load goes straight to DONE; start held in DONE reloads
    load_val = 8'd0; start = 1'b1;
    tick();
    chk("zero_state", state0, 3);
    chk("zero_done", done0, 1);
    chk("zero_busy", busy0, 0);
    load_val = 8'd3;
    tick();
    chk("zero_restart_state", state0, 1);
    chk("zero_restart_count", count0, 3);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;

    // Auto-reload instance: done every 4 cycles with load 3
    load_val = 8'd3; start = 1'b1;
    tick();
    chk("ar_first", count1, 3);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("ar_count", count1, 3 - (i % 4));
      chk("ar_done", done1, (i % 4 == 3));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Random traffic against the model
    repeat (3000) begin
      start    = ($urandom % 4) == 0;
      abort    = ($urandom % 16) == 0;
      en       = ($urandom % 4) != 0;
      load_val = ($urandom % 2 == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom % 256);
      if ($urandom % 500 == 0) begin
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        reset_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
